// File: rtl/brcomp_pkg.sv
// brcomp_pkg: shared types and helpers for the
// multi-cycle sliced branch comparator.
package brcomp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  function automatic bit slices_ok(input int width, input int slice);
    return (slice > 0) && (width >= slice) && (width % slice == 0);
  endfunction

endpackage

// File: rtl/brcomp_slice.sv
// brcomp_slice: combinational unsigned comparator
// for one SLICE-bit operand slice.
module brcomp_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             lt_o,
  output logic             eq_o
);

  assign lt_o = (a_i < b_i);
  assign eq_o = (a_i == b_i);

endmodule

// File: rtl/brcomp_seq.sv
// brcomp_seq: MSB-first sliced branch comparator with
// valid/ready on both sides and a pipeline flush.
module brcomp_seq
  import brcomp_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SLICE      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] rs1_data_i,
  input  logic [WIDTH-1:0] rs2_data_i,
  input  logic             br_unsign_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             br_less_o,
  output logic             br_equal_o
);

  localparam int NS = nslice(WIDTH, SLICE);
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NS - 1);
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

  if (!slices_ok(WIDTH, SLICE)) begin : g_bad_cfg
    $error("brcomp_seq: WIDTH must be a multiple of SLICE");
  end

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              pl_q, pl_d, pd_q, pd_d;
  logic              less_q, less_d, eq_q, eq_d;
  logic [SLICE-1:0]  sa, sb;
  logic              s_lt, s_eq, fin;

  // Select the slice under evaluation from the index counter
  always_comb begin
    sa = a_q[int'(idx_q)*SLICE +: SLICE];
    sb = b_q[int'(idx_q)*SLICE +: SLICE];
  end

  brcomp_slice #(.SLICE(SLICE)) u_slice (
    .a_i  (sa),
    .b_i  (sb),
    .lt_o (s_lt),
    .eq_o (s_eq)
  );

  assign fin = (EARLY_EXIT && !s_eq) || (idx_q == '0);

  // Next-state: accept, step slices, publish result, handshake out
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    pl_d    = pl_q;
    pd_d    = pd_q;
    less_d  = less_q;
    eq_d    = eq_q;
    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          state_d = ST_CMP;
          a_d     = br_unsign_i ? rs1_data_i : rs1_data_i ^ MSB;
          b_d     = br_unsign_i ? rs2_data_i : rs2_data_i ^ MSB;
          idx_d   = IDX_TOP;
          pl_d    = 1'b0;
          pd_d    = 1'b0;
        end
      end
      ST_CMP: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          if (!s_eq && !pd_q) begin
            pl_d = s_lt;
            pd_d = 1'b1;
          end
          if (fin) begin
            state_d = ST_DONE;
            less_d  = pd_q ? pl_q : (!s_eq && s_lt);
            eq_d    = !pd_q && s_eq;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (flush_i || ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      pl_q    <= 1'b0;
      pd_q    <= 1'b0;
      less_q  <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      pl_q    <= pl_d;
      pd_q    <= pd_d;
      less_q  <= less_d;
      eq_q    <= eq_d;
    end
  end

  assign ready_o    = (state_q == ST_IDLE);
  assign valid_o    = (state_q == ST_DONE);
  assign br_less_o  = less_q;
  assign br_equal_o = eq_q;

endmodule

// File: tb/tb_brcomp_seq.sv
// tb_brcomp_seq: directed vectors for brcomp_seq,
// early-exit and constant-latency instances.
module tb_brcomp_seq;

  logic        clk, rst, flush;
  logic        valid1, valid2, rdyi1, rdyi2;
  logic [31:0] rs1, rs2;
  logic        unsg;
  logic        rdyo1, vo1, less1, eq1;
  logic        rdyo2, vo2, less2, eq2;
  logic        sel;
  logic        ready_x, valid_x, less_x, eq_x;
  int          nvec, nerr;

  brcomp_seq #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(valid1), .ready_o(rdyo1),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .br_unsign_i(unsg),
    .valid_o(vo1), .ready_i(rdyi1),
    .br_less_o(less1), .br_equal_o(eq1)
  );

  brcomp_seq #(.WIDTH(32), .SLICE(8), .EARLY_EXIT(1'b0)) dut_cl (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .valid_i(valid2), .ready_o(rdyo2),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .br_unsign_i(unsg),
    .valid_o(vo2), .ready_i(rdyi2),
    .br_less_o(less2), .br_equal_o(eq2)
  );

  assign ready_x = sel ? rdyo2 : rdyo1;
  assign valid_x = sel ? vo2   : vo1;
  assign less_x  = sel ? less2 : less1;
  assign eq_x    = sel ? eq2   : eq1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run(input string tag, input bit s,
                     input logic [31:0] a, input logic [31:0] b,
                     input bit uns, input bit el, input bit ee,
                     input int ed);
    int d;
    d   = 0;
    sel = s;
    @(posedge clk); #1;
    check({tag, ".rdy"}, 32'(ready_x), 32'd1);
    rs1 = a; rs2 = b; unsg = uns;
    if (s) valid2 = 1'b1;
    else   valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0; valid2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (valid_x) begin
        d = k;
        break;
      end
    end
    check({tag, ".lat"}, 32'(d), 32'(ed));
    check({tag, ".less"}, 32'(less_x), 32'(el));
    check({tag, ".eq"}, 32'(eq_x), 32'(ee));
    if (s) rdyi2 = 1'b1;
    else   rdyi1 = 1'b1;
    @(posedge clk); #1;
    rdyi1 = 1'b0; rdyi2 = 1'b0;
    check({tag, ".vdrop"}, 32'(valid_x), 32'd0);
    check({tag, ".rdyback"}, 32'(ready_x), 32'd1);
  endtask

  initial begin
    nvec = 0; nerr = 0; sel = 1'b0;
    rst = 1'b1; flush = 1'b0;
    valid1 = 1'b0; valid2 = 1'b0; rdyi1 = 1'b0; rdyi2 = 1'b0;
    rs1 = '0; rs2 = '0; unsg = 1'b1;
    #12 rst = 1'b0;
    #1;
    check("rst.rdy", 32'(rdyo1), 32'd1);
    check("rst.valid", 32'(vo1), 32'd0);
    check("rst.less", 32'(less1), 32'd0);
    check("rst.eq", 32'(eq1), 32'd0);

    run("u_1_max",   0, 32'h0000_0001, 32'hFFFF_FFFF, 1, 1, 0, 1);
    run("s_m1_1",    0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1, 0, 1);
    run("u_max_1",   0, 32'hFFFF_FFFF, 32'h0000_0001, 1, 0, 0, 1);
    run("u_eq",      0, 32'h1234_5678, 32'h1234_5678, 1, 0, 1, 4);
    run("s_eq",      0, 32'h1234_5678, 32'h1234_5678, 0, 0, 1, 4);
    run("u_lsb",     0, 32'h1234_5678, 32'h1234_5679, 1, 1, 0, 4);
    run("s_min_0",   0, 32'h8000_0000, 32'h0000_0000, 0, 1, 0, 1);
    run("s_5_m3",    0, 32'h0000_0005, 32'hFFFF_FFFD, 0, 0, 0, 1);
    run("u_slice2",  0, 32'h0001_0000, 32'h0002_0000, 1, 1, 0, 2);
    run("cl_msb",    1, 32'h8000_0000, 32'h0000_0000, 1, 0, 0, 4);
    run("cl_first",  1, 32'h0100_0000, 32'h00FF_FFFF, 1, 0, 0, 4);
    run("cl_low",    1, 32'h0000_0005, 32'h0000_0009, 1, 1, 0, 4);
    run("cl_eq",     1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 1, 4);

    // backpressure: DONE held while inputs wiggle
    sel = 1'b0;
    @(posedge clk); #1;
    rs1 = 32'h0000_0001; rs2 = 32'hFFFF_FFFF; unsg = 1'b1;
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    @(posedge clk); #1;
    check("bp.valid0", 32'(vo1), 32'd1);
    for (int k = 0; k < 3; k++) begin
      valid1 = ~valid1;
      rs1 = 32'hFFFF_FFFF - 32'(k);
      rs2 = 32'(k);
      unsg = k[0];
      @(posedge clk); #1;
      check("bp.valid", 32'(vo1), 32'd1);
      check("bp.less", 32'(less1), 32'd1);
      check("bp.eq", 32'(eq1), 32'd0);
      check("bp.rdy", 32'(rdyo1), 32'd0);
    end
    valid1 = 1'b0;
    rdyi1 = 1'b1;
    @(posedge clk); #1;
    rdyi1 = 1'b0;
    check("bp.release", 32'(vo1), 32'd0);

    // flush two cycles into a 4-slice compare
    run("pre_flush", 0, 32'h1234_5678, 32'h1234_5678, 1, 0, 1, 4);
    @(posedge clk); #1;
    rs1 = 32'h1234_5678; rs2 = 32'h1234_5679; unsg = 1'b1;
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    @(posedge clk); #1;
    check("fl.busy", 32'(rdyo1), 32'd0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl.valid", 32'(vo1), 32'd0);
    check("fl.rdy", 32'(rdyo1), 32'd1);
    check("fl.less", 32'(less1), 32'd0);
    check("fl.eq", 32'(eq1), 32'd1);
    run("post_flush", 0, 32'h0001_0000, 32'h0002_0000, 1, 1, 0, 2);

    // asynchronous reset in the middle of CMP
    @(posedge clk); #1;
    rs1 = 32'h1234_5678; rs2 = 32'h1234_5678; unsg = 1'b1;
    valid1 = 1'b1;
    @(posedge clk); #1;
    valid1 = 1'b0;
    @(posedge clk); #3;
    check("ar.busy", 32'(rdyo1), 32'd0);
    rst = 1'b1;
    #1;
    check("ar.valid", 32'(vo1), 32'd0);
    check("ar.less", 32'(less1), 32'd0);
    check("ar.eq", 32'(eq1), 32'd0);
    check("ar.rdy", 32'(rdyo1), 32'd1);
    #2 rst = 1'b0;
    run("post_rst", 0, 32'h0000_0001, 32'hFFFF_FFFF, 1, 1, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/brcomp_seq.md
# brcomp_seq

Parametrised multi-cycle branch comparator for the RV32 core's multi-cycle and low-area configurations. It compares two WIDTH-bit operands SLICE bits per cycle, most significant slice first, in signed or unsigned mode, and produces br_less/br_equal for the branch unit. A valid/ready handshake sits on each side. A flush input aborts an in-flight compare on a pipeline redirect.

## Interface
- WIDTH, 32: operand width; must be a multiple of SLICE.
- SLICE, 8: bits compared per cycle; NSLICE = WIDTH/SLICE, and NSLICE ≥ 1.
- EARLY_EXIT, 1: 1 = finish on the first differing slice; 0 = always take NSLICE cycles (constant latency).
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  synchronous abort of the current compare.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted; high only in IDLE.
- rs1_data_i  in  WIDTH  operand A.
- rs2_data_i  in  WIDTH  operand B.
- br_unsign_i  in  1  1 = unsigned compare, 0 = signed (two's complement).
- valid_o  out  1  result valid; held until ready_i.
- ready_i  in  1  consumer accepts the result.
- br_less_o  out  1  A < B in the selected mode.
- br_equal_o  out  1  A == B.

## Operation
- States: IDLE, CMP, DONE.
- IDLE:
  - ready_o = 1.
  - On valid_i & ready_o, latch both operands and go to CMP with slice index = NSLICE-1.
  - In signed mode, bit WIDTH-1 of both latched operands is inverted. This turns the signed compare into an unsigned one; there is no other signed path.
- CMP: each cycle, compare the indexed slice of A and B as unsigned values.
  - Slices differ, EARLY_EXIT=1: set less = (sliceA < sliceB), equal = 0, go to DONE.
  - Slices differ, EARLY_EXIT=0: record less/equal for the first difference only, keep stepping.
  - Slices equal at index 0 with no difference recorded: less = 0, equal = 1, go to DONE.
  - At index 0, EARLY_EXIT=0 always goes to DONE.
- DONE:
  - valid_o = 1; br_less_o and br_equal_o are stable.
  - On ready_i, go to IDLE.
- ready_o = 0 in CMP and DONE. valid_i is ignored there, and operand inputs may change freely.
- br_less_o and br_equal_o are registered. They keep the last completed result outside DONE, and are never both 1.
- flush_i in CMP or DONE: go to IDLE on the next edge. valid_o drops and the result registers are unchanged. flush_i has priority over completion and over ready_i. flush_i in IDLE is ignored and does not block acceptance in the same cycle.
- rst_i, any state and any time: state = IDLE, valid_o = 0, br_less_o = 0, br_equal_o = 0, latched operands and index cleared. ready_o = 1 once the state is IDLE.

## Timing
- Let the accept edge be E0. The slice NSLICE-j is evaluated in the cycle ending at edge E0+j.
- Latency with EARLY_EXIT=1: valid_o rises after edge E0+d.
  - d = 1-based position, counted from the MSB, of the first differing slice.
  - d = NSLICE for equal operands.
- Latency with EARLY_EXIT=0: valid_o rises after E0+NSLICE for every input.
- Handshake back-to-back: if ready_i is high when valid_o rises, DONE lasts one cycle. ready_o returns the next cycle, so the minimum period is d+2 cycles.
- No combinational path from any input to any output. ready_o and valid_o decode the state register.

## Structure
- Package brcomp_pkg holds:
  - the state enum (IDLE/CMP/DONE);
  - the NSLICE computation function;
  - an elaboration-time check that WIDTH % SLICE == 0.
- Sub-module brcomp_slice: combinational SLICE-bit unsigned comparator with outputs lt and eq, instantiated once. The slice select is a mux on the index counter.
- Index counter width: $clog2(NSLICE), minimum 1.

## Test plan
Defaults WIDTH=32, SLICE=8, EARLY_EXIT=1 unless stated.
- Unsigned, A=0x0000_0001, B=0xFFFF_FFFF -> less=1, equal=0, valid_o after E0+1.
- Signed, A=0xFFFF_FFFF (-1), B=0x0000_0001 -> less=1, equal=0 at E0+1. Same operands unsigned -> less=0, equal=0.
- A=B=0x1234_5678, either mode -> equal=1, less=0 at E0+4.
- A=0x1234_5678, B=0x1234_5679, unsigned -> less=1 at E0+4.
- EARLY_EXIT=0, A=0x8000_0000, B=0, unsigned -> less=0, equal=0 at E0+4, not at E0+1.
- Backpressure: hold ready_i=0 for 3 cycles in DONE while toggling valid_i and the operands -> valid_o, br_less_o and br_equal_o stable, ready_o=0.
- flush_i at E0+2 of a 4-slice compare -> IDLE next edge, valid_o=0, prior result retained, new request accepted.
- rst_i asserted mid-CMP, asynchronously between edges -> all outputs 0 immediately, ready_o=1.
